// File: rtl/pipe_control_unit_if.sv
// Fetch/decode handshake for pipe_control_unit: instruction fields toward
// decode, accept and PC-advance strobes back toward fetch.
interface pipe_control_unit_if;
    logic       instr_valid;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       instr_ready;
    logic       pc_en;

    modport master (
        output instr_valid, opcode, funct, rs, rt, rd,
        input  instr_ready, pc_en
    );

    modport slave (
        input  instr_valid, opcode, funct, rs, rt, rd,
        output instr_ready, pc_en
    );
endinterface

// File: rtl/pipe_control_unit.sv
// Registered MIPS control unit: decodes the fetched instruction and carries the
// control word through STAGES registers with load-use interlock, freeze, flush and halt.
module pipe_control_unit #(
    parameter int unsigned STAGES    = 3,
    parameter bit          HAZARD_EN = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    pipe_control_unit_if.slave     fe,
    input  logic                   stall_ext,
    input  logic                   flush,
    output logic [STAGES*28-1:0]   ctrl_q,
    output logic                   halted,
    output logic [CNT_W-1:0]       stall_count
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
        OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
        OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E,
        OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B, OP_LL   = 6'h30,
        OP_SC    = 6'h38, OP_HALT  = 6'h3F
    } opcode_e;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08, FN_ADD = 6'h20,
        FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
        FN_OR   = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
        ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
        ALU_SLL = 4'd8, ALU_SRL = 4'd9
    } alu_e;

    typedef struct packed {
        logic       pad;
        logic [4:0] wdest;
        logic       valid;
        logic       halt;
        logic       reg_wen;
        logic [1:0] bra;
        logic       check_over;
        logic       mem_read;
        logic       mem_write;
        logic       lui_src;
        logic       ext_src;
        logic [1:0] pc_src;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [1:0] portb_src;
        logic [3:0] alu_op;
    } ctrl_t;

    opcode_e    op;
    funct_e     fn;
    ctrl_t      dec;
    logic       known;
    logic [4:0] dest;
    logic       reads_rt;
    logic       hazard;
    logic       take;
    logic       halt_seen;
    ctrl_t      stage_q [STAGES];
    ctrl_t      stage_d [STAGES];

    assign op = opcode_e'(fe.opcode);
    assign fn = funct_e'(fe.funct);

    always_comb begin
        dec           = '0;
        dec.portb_src = 2'b01;
        dec.reg_dst   = 2'b01;
        dec.reg_wen   = 1'b1;
        dec.valid     = 1'b1;
        known         = 1'b1;
        dest          = '0;
        case (op)
            OP_RTYPE: begin
                dec.portb_src = 2'b00;
                dec.reg_dst   = 2'b00;
                case (fn)
                    FN_SLL:  begin dec.portb_src = 2'b10; dec.alu_op = ALU_SLL; end
                    FN_SRL:  begin dec.portb_src = 2'b10; dec.alu_op = ALU_SRL; end
                    FN_JR:   begin dec.pc_src = 2'b11; dec.reg_wen = 1'b0; end
                    FN_ADD:  dec.check_over = 1'b1;
                    FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUB:  begin dec.alu_op = ALU_SUB; dec.check_over = 1'b1; end
                    FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_XOR:  dec.alu_op = ALU_XOR;
                    FN_NOR:  dec.alu_op = ALU_NOR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLTU: dec.alu_op = ALU_SLTU;
                    default: known = 1'b0;
                endcase
            end
            OP_J:     begin dec.pc_src = 2'b10; dec.reg_wen = 1'b0; end
            OP_JAL:   begin dec.pc_src = 2'b10; dec.reg_dst = 2'b10; dec.mem_to_reg = 2'b10; end
            OP_BEQ, OP_BNE: begin
                dec.alu_op    = ALU_SUB;
                dec.pc_src    = 2'b01;
                dec.portb_src = 2'b00;
                dec.bra       = (op == OP_BEQ) ? 2'b01 : 2'b10;
                dec.reg_wen   = 1'b0;
            end
            OP_ADDI:  begin dec.ext_src = 1'b1; dec.check_over = 1'b1; end
            OP_ADDIU: dec.ext_src = 1'b1;
            OP_SLTI:  begin dec.ext_src = 1'b1; dec.check_over = 1'b1; dec.alu_op = ALU_SLT; end
            OP_SLTIU: begin dec.ext_src = 1'b1; dec.alu_op = ALU_SLTU; end
            OP_ANDI:  dec.alu_op = ALU_AND;
            OP_ORI:   dec.alu_op = ALU_OR;
            OP_XORI:  dec.alu_op = ALU_XOR;
            OP_LUI:   begin dec.alu_op = ALU_OR; dec.lui_src = 1'b1; end
            OP_LW:    begin dec.ext_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 2'b01; end
            OP_SW:    begin dec.ext_src = 1'b1; dec.mem_write = 1'b1; dec.reg_wen = 1'b0; end
            OP_LL, OP_SC: dec.reg_wen = 1'b0;
            OP_HALT:  begin dec.halt = 1'b1; dec.reg_wen = 1'b0; end
            default:  known = 1'b0;
        endcase
        if (!known) begin
            dec       = '0;
            dec.valid = 1'b1;
        end
        case (dec.reg_dst)
            2'b00:   dest = fe.rd;
            2'b01:   dest = fe.rt;
            default: dest = 5'd31;
        endcase
        dec.wdest = dec.reg_wen ? dest : '0;
    end

    assign reads_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    assign hazard   = HAZARD_EN && stage_q[0].valid && stage_q[0].mem_read &&
                      (stage_q[0].wdest != '0) &&
                      ((stage_q[0].wdest == fe.rs) || ((stage_q[0].wdest == fe.rt) && reads_rt));

    assign fe.instr_ready = !stall_ext && !hazard && !halt_seen;
    assign fe.pc_en       = fe.instr_ready;

    // Freeze is applied at the register, so take only decides bubble vs decoded word.
    assign take = fe.instr_valid && !hazard && !flush && !halt_seen;

    always_comb begin
        stage_d[0] = take ? dec : '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            halt_seen   <= 1'b0;
            halted      <= 1'b0;
            stall_count <= '0;
        end else begin
            if (!stall_ext) begin
                stage_q <= stage_d;
                if (take && dec.halt) begin
                    halt_seen <= 1'b1;
                end
                if (stage_d[STAGES-1].halt && stage_d[STAGES-1].valid) begin
                    halted <= 1'b1;
                end
            end
            if (!fe.pc_en && !halted && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        ctrl_q = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            ctrl_q[28*k +: 28] = stage_q[k];
        end
    end

endmodule
